ahb_burst_monitor: RTL and testbench

- Per-master, per-slave-port burst tracker that produces the `hlast` bit consumed by the arbiter's fixed-priority and burst-request grant-mask stages.
- Decodes the master's address-phase signals, counts accepted beats, and flags the address phase of the final beat of the current burst, so the arbiter can re-arbitrate on the next cycle.
- Caps undefined-length INCR bursts and stops them at 1KB address boundaries.
- One instance per master input of each arbiter.

---
 rtl/ahb_burst_monitor.sv | 125 ++++++++++++
 tb/tb_ahb_burst_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_monitor.sv
// ahb_burst_monitor
// Tracks one master's AHB burst on one slave port and flags the address
// phase of the final beat (hlast) so the arbiter can re-arbitrate on the
// following cycle. Undefined-length INCR bursts are capped at UNDL_LIMIT
// beats and are also cut at 1KB address boundaries.

module ahb_burst_monitor #(
  parameter int UNDL_LIMIT = 4,
  parameter int CNT_W      = 5
) (
  input  logic             hclk,
  input  logic             hreset_n,
  input  logic             hsel,
  input  logic [1:0]       htrans,
  input  logic [2:0]       hburst,
  input  logic [2:0]       hsize,
  input  logic [9:0]       haddr_low,
  input  logic             hready,
  output logic             hlast,
  output logic             burst_active,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [2:0] BURST_INCR   = 3'd1;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             incr_q, incr_d;
  logic [CNT_W-1:0] live_limit;
  logic [10:0]      next_addr;
  logic             bdr;
  logic             acc;
  logic             hlast_new;
  logic             hlast_seq;
  logic             hlast_int;

  // Decode the burst type on the bus into a beats-minus-one limit
  always_comb begin
    live_limit = '0;
    case (hburst)
      3'd0:       live_limit = '0;
      3'd1:       live_limit = CNT_W'(UNDL_LIMIT - 1);
      3'd2, 3'd3: live_limit = CNT_W'(3);
      3'd4, 3'd5: live_limit = CNT_W'(7);
      default:    live_limit = CNT_W'(15);
    endcase
  end

  // Next beat address would leave the current 1KB page (11-bit sum keeps the carry)
  assign next_addr = {1'b0, haddr_low} + (11'd1 << hsize);
  assign bdr       = (next_addr > 11'h3FF);

  assign acc = hsel & hready & htrans[1];

  // A NONSEQ (in either state) is judged by the live burst type; a SEQ in a
  // burst is judged by the latched limit and latched INCR flag
  assign hlast_new = hsel & (htrans == TRANS_NONSEQ) &
                     ((live_limit == '0) | ((hburst == BURST_INCR) & bdr));
  assign hlast_seq = hsel & (htrans == TRANS_SEQ) &
                     ((beat_cnt == lim_q) | (incr_q & bdr));
  assign hlast_int = ((state_q == ST_BURST) && (htrans == TRANS_SEQ)) ? hlast_seq : hlast_new;

  assign hlast        = hreset_n & hlast_int;
  assign burst_active = (state_q == ST_BURST);

  // State, beat counter and latched burst attributes
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= ST_IDLE;
      beat_cnt <= '0;
      lim_q    <= '0;
      incr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= cnt_d;
      lim_q    <= lim_d;
      incr_q   <= incr_d;
    end
  end

  // Next-state logic: a new burst always restarts tracking, otherwise SEQ
  // beats advance the count and IDLE/loss of hsel abandon the burst
  always_comb begin
    state_d = state_q;
    cnt_d   = beat_cnt;
    lim_d   = lim_q;
    incr_d  = incr_q;
    if (acc && (htrans == TRANS_NONSEQ)) begin
      lim_d  = live_limit;
      incr_d = (hburst == BURST_INCR);
      if (hlast_new) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_BURST;
        cnt_d   = CNT_W'(1);
      end
    end else if (state_q == ST_BURST) begin
      if (!hsel) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (hready && (htrans == TRANS_SEQ)) begin
        if (hlast_seq) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = beat_cnt + CNT_W'(1);
        end
      end else if (hready && (htrans == TRANS_IDLE)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_burst_monitor.sv
// tb_ahb_burst_monitor
// Directed vector table for the burst scenarios, a hand-written mid-burst
// reset sequence, and a randomized run against a transaction-level model.

module tb_ahb_burst_monitor;

  localparam int UNDL = 4;
  localparam int CW   = 5;

  logic          hclk;
  logic          hreset_n;
  logic          hsel;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic [9:0]    haddr_low;
  logic          hready;
  logic          hlast;
  logic          burst_active;
  logic [CW-1:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  ahb_burst_monitor #(.UNDL_LIMIT(UNDL), .CNT_W(CW)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .htrans(htrans),
    .hburst(hburst), .hsize(hsize), .haddr_low(haddr_low), .hready(hready),
    .hlast(hlast), .burst_active(burst_active), .beat_cnt(beat_cnt)
  );

  // Free-running clock, period 10
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic       sel;
    logic [1:0] trans;
    logic [2:0] burst;
    logic [2:0] size;
    logic [9:0] addr;
    logic       ready;
    logic       exp_hlast;
    logic       exp_active;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic s, input logic [1:0] t, input logic [2:0] b,
                        input logic [2:0] z, input logic [9:0] a, input logic r,
                        input logic eh, input logic ea, input int ec);
    vec_t v;
    v.sel = s; v.trans = t; v.burst = b; v.size = z; v.addr = a; v.ready = r;
    v.exp_hlast = eh; v.exp_active = ea; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  // Drive one address phase at the falling edge and let it settle
  task automatic applyStimulus(input logic s, input logic [1:0] t, input logic [2:0] b,
                               input logic [2:0] z, input logic [9:0] a, input logic r);
    @(negedge hclk);
    hsel = s; htrans = t; hburst = b; hsize = z; haddr_low = a; hready = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eh, input logic ea, input int ec);
    checkOutput({tag, " hlast"}, int'(hlast), int'(eh));
    checkOutput({tag, " burst_active"}, int'(burst_active), int'(ea));
    checkOutput({tag, " beat_cnt"}, int'(beat_cnt), ec);
  endtask

  // Transaction-level reference: beats done so far out of a total beat count
  bit m_active;
  int m_done;
  int m_total;
  bit m_incr;

  function automatic int burstBeats(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return UNDL;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic bit crossesPage(input logic [9:0] a, input logic [2:0] z);
    return (int'(a) + (1 << z)) > 1023;
  endfunction

  function automatic bit modelLast(input logic s, input logic [1:0] t, input logic [2:0] b,
                                   input logic [2:0] z, input logic [9:0] a);
    if (!s) return 1'b0;
    if (t == 2'd2) return (burstBeats(b) == 1) || ((b == 3'd1) && crossesPage(a, z));
    if (t == 2'd3 && m_active) return (m_done + 1 == m_total) || (m_incr && crossesPage(a, z));
    return 1'b0;
  endfunction

  task automatic modelStep(input logic s, input logic [1:0] t, input logic [2:0] b,
                           input logic r, input bit last);
    if (!s) begin
      m_active = 0; m_done = 0;
    end else if (r) begin
      case (t)
        2'd2: begin
          m_total = burstBeats(b);
          m_incr  = (b == 3'd1);
          if (last) begin m_active = 0; m_done = 0; end
          else begin m_active = 1; m_done = 1; end
        end
        2'd3: if (m_active) begin
          if (last) begin m_active = 0; m_done = 0; end
          else m_done++;
        end
        2'd0: begin m_active = 0; m_done = 0; end
        default: ;
      endcase
    end
  endtask

  initial begin
    hreset_n = 1'b0;
    hsel = 0; htrans = 0; hburst = 0; hsize = 0; haddr_low = 0; hready = 1;

    // SINGLE
    addVec(1, 2, 0, 2, 10'h000, 1, 1, 0, 0);
    addVec(1, 0, 0, 2, 10'h000, 1, 0, 0, 0);
    // INCR4, back-to-back
    addVec(1, 2, 3, 2, 10'h000, 1, 0, 0, 0);
    addVec(1, 3, 3, 2, 10'h004, 1, 0, 1, 1);
    addVec(1, 3, 3, 2, 10'h008, 1, 0, 1, 2);
    addVec(1, 3, 3, 2, 10'h00C, 1, 1, 1, 3);
    addVec(1, 0, 3, 2, 10'h000, 1, 0, 0, 0);
    // INCR4 with BUSY before beat 3 and a stalled final beat
    addVec(1, 2, 3, 2, 10'h000, 1, 0, 0, 0);
    addVec(1, 3, 3, 2, 10'h004, 1, 0, 1, 1);
    addVec(1, 1, 3, 2, 10'h008, 1, 0, 1, 2);
    addVec(1, 1, 3, 2, 10'h008, 1, 0, 1, 2);
    addVec(1, 3, 3, 2, 10'h008, 1, 0, 1, 2);
    addVec(1, 3, 3, 2, 10'h00C, 0, 1, 1, 3);
    addVec(1, 3, 3, 2, 10'h00C, 0, 1, 1, 3);
    addVec(1, 3, 3, 2, 10'h00C, 1, 1, 1, 3);
    addVec(1, 0, 3, 2, 10'h000, 1, 0, 0, 0);
    // Undefined-length INCR capped at UNDL beats, extra SEQ beats ignored
    addVec(1, 2, 1, 2, 10'h100, 1, 0, 0, 0);
    addVec(1, 3, 1, 2, 10'h104, 1, 0, 1, 1);
    addVec(1, 3, 1, 2, 10'h108, 1, 0, 1, 2);
    addVec(1, 3, 1, 2, 10'h10C, 1, 1, 1, 3);
    addVec(1, 3, 1, 2, 10'h110, 1, 0, 0, 0);
    addVec(1, 3, 1, 2, 10'h114, 1, 0, 0, 0);
    // INCR stopped at the 1KB boundary on beat 2
    addVec(1, 2, 1, 2, 10'h3F8, 1, 0, 0, 0);
    addVec(1, 3, 1, 2, 10'h3FC, 1, 1, 1, 1);
    addVec(1, 0, 1, 2, 10'h000, 1, 0, 0, 0);
    // INCR first beat already at the boundary: single-beat burst
    addVec(1, 2, 1, 3, 10'h3F8, 1, 1, 0, 0);
    addVec(1, 0, 1, 3, 10'h000, 1, 0, 0, 0);
    // INCR8 ending on the boundary is not cut early
    addVec(1, 2, 5, 2, 10'h3E0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      addVec(1, 3, 5, 2, 10'(10'h3E0 + 4 * k), 1, 0, 1, k);
    addVec(1, 3, 5, 2, 10'h3FC, 1, 1, 1, 7);
    addVec(1, 0, 5, 2, 10'h000, 1, 0, 0, 0);
    // INCR16 abandoned by hsel dropping
    addVec(1, 2, 7, 2, 10'h000, 1, 0, 0, 0);
    addVec(1, 3, 7, 2, 10'h004, 1, 0, 1, 1);
    addVec(1, 3, 7, 2, 10'h008, 1, 0, 1, 2);
    addVec(0, 3, 7, 2, 10'h00C, 1, 0, 1, 3);
    addVec(0, 0, 7, 2, 10'h000, 1, 0, 0, 0);
    // Restart by NONSEQ inside a burst, then early IDLE termination
    addVec(1, 2, 3, 2, 10'h000, 1, 0, 0, 0);
    addVec(1, 3, 3, 2, 10'h004, 1, 0, 1, 1);
    addVec(1, 2, 0, 2, 10'h200, 1, 1, 1, 2);
    addVec(1, 0, 0, 2, 10'h000, 1, 0, 0, 0);
    addVec(1, 2, 5, 2, 10'h300, 1, 0, 0, 0);
    addVec(1, 2, 3, 2, 10'h340, 1, 0, 1, 1);
    addVec(1, 3, 3, 2, 10'h344, 1, 0, 1, 1);
    addVec(1, 0, 3, 2, 10'h000, 1, 0, 1, 2);
    addVec(1, 0, 3, 2, 10'h000, 1, 0, 0, 0);

    // hlast held low while reset is asserted, even for a SINGLE
    repeat (2) @(negedge hclk);
    applyStimulus(1, 2, 0, 2, 10'h000, 1);
    checkAll("reset", 0, 0, 0);
    hreset_n = 1'b1;

    foreach (vecs[i])
      begin
        applyStimulus(vecs[i].sel, vecs[i].trans, vecs[i].burst, vecs[i].size,
                      vecs[i].addr, vecs[i].ready);
        checkAll($sformatf("vec%0d", i), vecs[i].exp_hlast, vecs[i].exp_active, vecs[i].exp_cnt);
      end

    // WRAP8 interrupted by reset after beat 3
    applyStimulus(1, 2, 4, 2, 10'h040, 1);
    checkAll("wrap8 b1", 0, 0, 0);
    applyStimulus(1, 3, 4, 2, 10'h044, 1);
    checkAll("wrap8 b2", 0, 1, 1);
    applyStimulus(1, 3, 4, 2, 10'h048, 1);
    checkAll("wrap8 b3", 0, 1, 2);
    applyStimulus(1, 3, 4, 2, 10'h04C, 1);
    checkAll("wrap8 b4", 0, 1, 3);
    #1 hreset_n = 1'b0;
    #1 checkAll("async reset", 0, 0, 0);
    applyStimulus(1, 3, 4, 2, 10'h050, 1);
    checkAll("in reset", 0, 0, 0);
    hreset_n = 1'b1;
    applyStimulus(1, 2, 0, 2, 10'h060, 1);
    checkAll("post-reset single", 1, 0, 0);
    applyStimulus(1, 3, 4, 2, 10'h064, 1);
    checkAll("no resume", 0, 0, 0);

    // Randomized run against the reference model
    applyStimulus(0, 0, 0, 0, 10'h000, 1);
    hreset_n = 1'b0;
    #1 hreset_n = 1'b1;
    m_active = 0; m_done = 0; m_total = 1; m_incr = 0;
    for (int n = 0; n < 3000; n++) begin
      logic       s, r, rst;
      logic [1:0] t;
      logic [2:0] b, z;
      logic [9:0] a;
      int         w;
      bit         el;
      rst = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 9) != 0);
      r   = ($urandom_range(0, 4) != 0);
      w   = $urandom_range(0, 9);
      t   = (w == 0) ? 2'd0 : (w == 1) ? 2'd1 : (w < 4) ? 2'd2 : 2'd3;
      b   = 3'($urandom_range(0, 7));
      z   = 3'($urandom_range(0, 3));
      a   = ($urandom_range(0, 3) == 0) ? 10'(1024 - $urandom_range(1, 16)) : 10'($urandom);
      @(negedge hclk);
      hreset_n = ~rst;
      hsel = s; htrans = t; hburst = b; hsize = z; haddr_low = a; hready = r;
      #1;
      if (rst) begin
        m_active = 0; m_done = 0; m_total = 1; m_incr = 0;
        checkAll($sformatf("rnd%0d", n), 0, 0, 0);
      end else begin
        el = modelLast(s, t, b, z, a);
        checkAll($sformatf("rnd%0d", n), el, m_active, m_done);
        modelStep(s, t, b, r, el);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
